mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the CPU's instruction-fetch path and its load/store path.
- Sequences each access with a fixed-latency wait counter and returns read data with a one-cycle ack.
- The core stalls on the missing ack.
- Sits between CPU and memory, in place of the direct pc-to-inst_mem connection.

Parameters:
- XLEN, 32, address and data width.
- MEM_LATENCY, 1, cycles from mem_en sample to valid mem_rdata; legal 1..15.
- CNT_W, 4, width of the latency counter; must hold MEM_LATENCY.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  XLEN  fetch byte address.
- if_rdata  output  XLEN  fetched instruction; valid when if_ack=1.
- if_ack  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  XLEN  data byte address.
- d_wdata  input  XLEN  store data.
- d_wstrb  input  4  store byte enables.
- d_rdata  output  XLEN  load data; valid when d_ack=1.
- d_ack  output  1  one-cycle data completion pulse.
- mem_en  output  1  one-cycle memory access strobe.
- mem_we  output  1  write enable, qualified by mem_en.
- mem_addr  output  XLEN  registered memory address.
- mem_wdata  output  XLEN  registered write data.
- mem_wstrb  output  4  registered byte enables; 0 for reads.
- mem_rdata  input  XLEN  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and the counter to 0.
  - Every output goes to 0.
  - The grant-owner register goes to FETCH.
- An in-flight access is abandoned on reset. No ack is issued for it. Memory side effects of an already-issued store are not undone.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: sample if_req and d_req.
    - Neither high: stay.
    - One high: grant it.
    - Both high: pick the winner per the arbitration rule.
    - On grant, latch owner, addr, wdata, wstrb and we (we and wstrb forced to 0 for fetch), then go to ISSUE.
  - ISSUE: mem_en=1 for exactly this cycle with the latched fields. Load cnt=1 and go to WAIT.
  - WAIT: when cnt==MEM_LATENCY, capture mem_rdata into the owner's rdata register and go to RESP; else cnt+1.
  - RESP: the owner's ack=1 for exactly this cycle, then go to IDLE. The other port's ack stays 0.
- Latency: a request sampled in IDLE at edge N gives mem_en high in cycle N+1 and ack high in cycle N+2+MEM_LATENCY.
- Throughput: one access per MEM_LATENCY+3 cycles.
- Handshake:
  - The requester holds req and its fields stable until ack.
  - Fields are latched at grant, so changes after grant are ignored.
  - Dropping req after grant does not abort; ack is still issued.
  - A req held high through its own RESP cycle is treated as a new request in the following IDLE cycle.
- rdata registers hold their last captured value between acks. Store completion also captures mem_rdata; the value is don't-care for the requester.
- if_ack and d_ack are never high in the same cycle.
- mem_en is never high outside ISSUE.
- Arbitration with default build: fixed priority, data port wins any tie, so load/store beats the next fetch. Fetch can starve only if d_req is re-asserted every IDLE cycle; the CPU guarantees it does not.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: the tie is broken by the grant-owner register; the port not granted last wins.
  - The register updates at every grant.
  - Reset value FETCH means the first tie goes to the data port.
  - Uncontested grants still update the register.
- Undefined: fixed data-port priority as above; the grant-owner register is still kept but is ignored for arbitration.

Test Plan:
- Reset mid-access: assert reset=0 during WAIT of a store to 0x20.
  - All outputs 0 immediately.
  - No d_ack.
  - After release, busy=0 and the next if_req is served normally.
- Single fetch, MEM_LATENCY=1: if_req=1, if_addr=0x4, memory returns 0x00500093.
  - mem_en high in exactly one cycle with mem_addr=0x4 and mem_we=0.
  - if_ack one cycle, 3 cycles after the sampling edge, with if_rdata=0x00500093.
  - d_ack stays 0.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011.
  - mem_en/mem_we high together for one cycle with mem_wstrb=0011 and the latched data.
  - d_ack follows MEM_LATENCY+1 cycles later.
- Simultaneous requests, default build: if_req and d_req rise in the same cycle.
  - Data served first (d_ack), then fetch (if_ack) MEM_LATENCY+3 cycles later.
  - Never both acks in the same cycle.
- Same stimulus with ARB_ROUND_ROBIN_EN, repeated three times (each request re-raised the cycle after its ack):
  - Grant order is D, I, D, I, D, I.
- Field stability and latency, MEM_LATENCY=4:
  - if_addr changed from 0x8 to 0xC one cycle after grant, so mem_addr must stay 0x8.
  - if_ack arrives exactly 6 cycles after the sampling edge.
  - if_req dropped during WAIT must still produce if_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between the fetch port and the load/store port.
// Latency: a request sampled at edge N drives mem_en in cycle N+1 and its ack in cycle N+2+MEM_LATENCY.
// Backpressure: requesters hold req and fields until their ack pulse. Build option ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Owner encoding: 0 = fetch port, 1 = data port.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              mem_en_q, mem_en_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              tie_to_data;
  logic              pick_data;

  // Tie-break: fixed data priority, or alternate against the last grant owner.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_to_data = (owner_q == OWN_FETCH);
`else
    tie_to_data = 1'b1;
`endif
  end

  // Next-state, grant latching, counter and registered-output next values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    mem_en_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    pick_data  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          pick_data = d_req && (!if_req || tie_to_data);
          owner_d   = pick_data ? OWN_DATA : OWN_FETCH;
          if (pick_data) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            // Loads never carry byte enables to memory.
            wstrb_d = d_we ? d_wstrb : 4'b0000;
          end else begin
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            wstrb_d = 4'b0000;
          end
          // mem_en is registered, so raise it as we enter ISSUE.
          mem_en_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          // Stores also capture mem_rdata; the requester ignores it.
          if (owner_q == OWN_DATA) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and all output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      mem_en_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      mem_en_q   <= mem_en_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 (a_*), one at MEM_LATENCY=4 (b_*).
// Memory models return data only in the exact cycle MEM_LATENCY edges after mem_en was sampled.
// Expected ack cycles are counted from the edge that samples the request.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---- instance A: MEM_LATENCY = 1 ----
  logic        a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata;
  logic [3:0]  a_d_wstrb;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;
  logic [3:0]  a_mem_wstrb;

  // ---- instance B: MEM_LATENCY = 4 ----
  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
  logic [3:0]  b_d_wstrb;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
  logic [3:0]  b_mem_wstrb;

  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_wstrb(a_d_wstrb),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory contents: 0x4 holds an addi; everything else is a tagged address.
  function automatic logic [31:0] mem_f(input logic [31:0] ad);
    return (ad == 32'h4) ? 32'h0050_0093 : (ad ^ 32'hA5A5_0000);
  endfunction

  logic [31:0] a_la = '0, b_la = '0;
  int a_age = 0, b_age = 0;
  always @(posedge clk) begin
    if (a_mem_en) begin a_la <= a_mem_addr; a_age <= 1; end
    else if (a_age > 0 && a_age < 30) a_age <= a_age + 1;
    if (b_mem_en) begin b_la <= b_mem_addr; b_age <= 1; end
    else if (b_age > 0 && b_age < 30) b_age <= b_age + 1;
  end
  assign a_mem_rdata = (a_age == 1) ? mem_f(a_la) : 32'hBAD0_BAD0;
  assign b_mem_rdata = (b_age == 4) ? mem_f(b_la) : 32'hBAD0_BAD0;

  // Observation mux: sel=0 watches instance A, sel=1 watches instance B.
  logic sel = 1'b0;
  logic        o_en, o_we, o_iack, o_dack;
  logic [31:0] o_addr, o_wdata, o_irdata, o_drdata;
  logic [3:0]  o_wstrb;
  always_comb begin
    if (sel) begin
      o_en = b_mem_en; o_we = b_mem_we; o_iack = b_if_ack; o_dack = b_d_ack;
      o_addr = b_mem_addr; o_wdata = b_mem_wdata; o_irdata = b_if_rdata; o_drdata = b_d_rdata;
      o_wstrb = b_mem_wstrb;
    end else begin
      o_en = a_mem_en; o_we = a_mem_we; o_iack = a_if_ack; o_dack = a_d_ack;
      o_addr = a_mem_addr; o_wdata = a_mem_wdata; o_irdata = a_if_rdata; o_drdata = a_d_rdata;
      o_wstrb = a_mem_wstrb;
    end
  end

  // Recorded by observe()
  int          en_cnt, en_k, iack_cnt, iack_k, dack_cnt, dack_k;
  logic        both_ack, en_we;
  logic [31:0] en_addr, en_wdata, irdata, drdata;
  logic [3:0]  en_wstrb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records activity for ncyc cycles starting with the cycle right after the sampling
  // edge (k=0); drops each req on its ack, and drops if_req at k==drop_if_k.
  task automatic observe(input int ncyc, input int drop_if_k);
    en_cnt = 0; en_k = -1; iack_cnt = 0; iack_k = -1; dack_cnt = 0; dack_k = -1; both_ack = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) tick();
      if (k == drop_if_k) begin if (sel) b_if_req = 1'b0; else a_if_req = 1'b0; end
      if (o_en) begin
        en_cnt++;
        if (en_k < 0) begin
          en_k = k; en_addr = o_addr; en_we = o_we; en_wstrb = o_wstrb; en_wdata = o_wdata;
        end
      end
      if (o_iack && o_dack) both_ack = 1'b1;
      if (o_iack) begin
        iack_cnt++; iack_k = k; irdata = o_irdata;
        if (sel) b_if_req = 1'b0; else a_if_req = 1'b0;
      end
      if (o_dack) begin
        dack_cnt++; dack_k = k; drdata = o_drdata;
        if (sel) b_d_req = 1'b0; else a_d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_if_req = 0; a_d_req = 0; a_d_we = 0; a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0; a_d_wstrb = '0;
    b_if_req = 0; b_d_req = 0; b_d_we = 0; b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0; b_d_wstrb = '0;
    tick(); tick();
    tests_run++;
    if ({a_mem_en, a_mem_we, a_if_ack, a_d_ack, a_busy} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctrl_a got %b want 00000", {a_mem_en, a_mem_we, a_if_ack, a_d_ack, a_busy});
    end
    tests_run++;
    if ((a_mem_addr | a_mem_wdata | a_if_rdata | a_d_rdata | {28'd0, a_mem_wstrb}) !== 32'h0) begin
      tests_failed++; $display("FAIL reset_data_a got nonzero %h want 0", a_mem_addr | a_mem_wdata | a_if_rdata | a_d_rdata);
    end
    tests_run++;
    if ({b_mem_en, b_if_ack, b_d_ack, b_busy} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_ctrl_b got %b want 0000", {b_mem_en, b_if_ack, b_d_ack, b_busy});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    sel = 1'b0;
    a_if_addr = 32'h4; a_if_req = 1'b1;
    tick();
    observe(8, -1);
    tests_run++;
    if (en_cnt !== 1 || en_k !== 0) begin
      tests_failed++; $display("FAIL fetch_mem_en got cnt=%0d k=%0d want cnt=1 k=0", en_cnt, en_k);
    end
    tests_run++;
    if (en_addr !== 32'h4 || en_we !== 1'b0) begin
      tests_failed++; $display("FAIL fetch_mem_fields got addr=%h we=%b want 4/0", en_addr, en_we);
    end
    tests_run++;
    if (iack_cnt !== 1 || iack_k !== 2) begin
      tests_failed++; $display("FAIL fetch_ack got cnt=%0d k=%0d want cnt=1 k=2", iack_cnt, iack_k);
    end
    tests_run++;
    if (irdata !== 32'h0050_0093) begin
      tests_failed++; $display("FAIL fetch_rdata got %h want 00500093", irdata);
    end
    tests_run++;
    if (dack_cnt !== 0) begin
      tests_failed++; $display("FAIL fetch_no_dack got %0d want 0", dack_cnt);
    end
  endtask

  task automatic test_store();
    sel = 1'b0;
    a_d_we = 1'b1; a_d_addr = 32'h100; a_d_wdata = 32'hDEAD_BEEF; a_d_wstrb = 4'b0011; a_d_req = 1'b1;
    tick();
    observe(8, -1);
    tests_run++;
    if (en_cnt !== 1 || en_we !== 1'b1 || en_wstrb !== 4'b0011) begin
      tests_failed++; $display("FAIL store_strobe got cnt=%0d we=%b wstrb=%b want 1/1/0011", en_cnt, en_we, en_wstrb);
    end
    tests_run++;
    if (en_addr !== 32'h100 || en_wdata !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL store_fields got addr=%h wdata=%h want 100/deadbeef", en_addr, en_wdata);
    end
    tests_run++;
    if (dack_cnt !== 1 || (dack_k - en_k) !== 2) begin
      tests_failed++; $display("FAIL store_ack got cnt=%0d delay=%0d want 1/2", dack_cnt, dack_k - en_k);
    end
    tests_run++;
    if (iack_cnt !== 0) begin
      tests_failed++; $display("FAIL store_no_iack got %0d want 0", iack_cnt);
    end
    a_d_we = 1'b0;
  endtask

  task automatic test_load();
    sel = 1'b0;
    a_d_we = 1'b0; a_d_addr = 32'h40; a_d_wstrb = 4'b1111; a_d_req = 1'b1;
    tick();
    observe(8, -1);
    tests_run++;
    if (en_we !== 1'b0 || en_wstrb !== 4'b0000) begin
      tests_failed++; $display("FAIL load_strobe got we=%b wstrb=%b want 0/0000", en_we, en_wstrb);
    end
    tests_run++;
    if (dack_k !== 2 || drdata !== 32'hA5A5_0040) begin
      tests_failed++; $display("FAIL load_data got k=%0d rdata=%h want 2/a5a50040", dack_k, drdata);
    end
  endtask

  task automatic test_simultaneous();
    int exp_dk, exp_ik;
`ifdef ARB_ROUND_ROBIN_EN
    // Last grant was the load, so the fetch port wins this tie.
    exp_ik = 2; exp_dk = 6;
`else
    exp_dk = 2; exp_ik = 6;
`endif
    sel = 1'b0;
    a_if_addr = 32'h10; a_d_addr = 32'h44; a_d_we = 1'b0; a_if_req = 1'b1; a_d_req = 1'b1;
    tick();
    observe(12, -1);
    tests_run++;
    if (dack_k !== exp_dk || iack_k !== exp_ik) begin
      tests_failed++; $display("FAIL tie_order got dk=%0d ik=%0d want dk=%0d ik=%0d", dack_k, iack_k, exp_dk, exp_ik);
    end
    tests_run++;
    if (both_ack !== 1'b0 || en_cnt !== 2) begin
      tests_failed++; $display("FAIL tie_exclusive got both=%b en_cnt=%0d want 0/2", both_ack, en_cnt);
    end
    tests_run++;
    if (irdata !== 32'hA5A5_0010 || drdata !== 32'hA5A5_0044) begin
      tests_failed++; $display("FAIL tie_rdata got i=%h d=%h want a5a50010/a5a50044", irdata, drdata);
    end
  endtask

  task automatic test_latency4();
    sel = 1'b1;
    b_if_addr = 32'h8; b_if_req = 1'b1;
    tick();
    b_if_addr = 32'hC;
    observe(10, 2);
    tests_run++;
    if (en_cnt !== 1 || en_addr !== 32'h8) begin
      tests_failed++; $display("FAIL lat4_addr got cnt=%0d addr=%h want 1/8", en_cnt, en_addr);
    end
    tests_run++;
    if (iack_cnt !== 1 || iack_k !== 5) begin
      tests_failed++; $display("FAIL lat4_ack got cnt=%0d k=%0d want 1/5", iack_cnt, iack_k);
    end
    tests_run++;
    if (irdata !== 32'hA5A5_0008) begin
      tests_failed++; $display("FAIL lat4_rdata got %h want a5a50008", irdata);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    sel = 1'b0;
    a_d_we = 1'b1; a_d_addr = 32'h20; a_d_wdata = 32'h1234_5678; a_d_wstrb = 4'b1111; a_d_req = 1'b1;
    tick();   // sampling edge: ISSUE
    tick();   // WAIT
    reset = 1'b0;
    #1;
    tests_run++;
    if ({a_mem_en, a_mem_we, a_if_ack, a_d_ack, a_busy} !== 5'b0) begin
      tests_failed++; $display("FAIL midrst_ctrl got %b want 00000", {a_mem_en, a_mem_we, a_if_ack, a_d_ack, a_busy});
    end
    tests_run++;
    if ((a_mem_addr | a_mem_wdata | a_if_rdata | a_d_rdata | {28'd0, a_mem_wstrb}) !== 32'h0) begin
      tests_failed++; $display("FAIL midrst_data got nonzero %h want 0", a_mem_addr | a_mem_wdata | a_d_rdata);
    end
    a_d_req = 1'b0; a_d_we = 1'b0;
    tick(); tick();
    reset = 1'b1;
    observe(4, -1);
    tests_run++;
    if (dack_cnt !== 0 || a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_after got dack=%0d busy=%b want 0/0", dack_cnt, a_busy);
    end
    a_if_addr = 32'h4; a_if_req = 1'b1;
    tick();
    observe(8, -1);
    tests_run++;
    if (iack_k !== 2 || irdata !== 32'h0050_0093) begin
      tests_failed++; $display("FAIL midrst_fetch got k=%0d rdata=%h want 2/00500093", iack_k, irdata);
    end
  endtask

  task automatic test_round_robin();
    logic [47:0] got, want;
    int n;
    logic raise_d, raise_i, done;
`ifdef ARB_ROUND_ROBIN_EN
    want = "DIDIDI";
`else
    want = "DDDDDD";
`endif
    // Fresh reset puts the grant owner back at FETCH.
    reset = 1'b0; tick(); reset = 1'b1; tick();
    got = "------"; n = 0; raise_d = 1'b0; raise_i = 1'b0; done = 1'b0; both_ack = 1'b0;
    a_if_addr = 32'h4; a_d_addr = 32'h48; a_d_we = 1'b0; a_if_req = 1'b1; a_d_req = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (raise_d) begin a_d_req = 1'b1; raise_d = 1'b0; end
      if (raise_i) begin a_if_req = 1'b1; raise_i = 1'b0; end
      if (a_if_ack && a_d_ack) both_ack = 1'b1;
      if (a_d_ack) begin
        if (n < 6) got[8*(5-n) +: 8] = "D";
        n++; a_d_req = 1'b0; raise_d = (n < 6);
      end
      if (a_if_ack) begin
        if (n < 6) got[8*(5-n) +: 8] = "I";
        n++; a_if_req = 1'b0; raise_i = (n < 6);
      end
      done = !a_if_req && !a_d_req && !raise_d && !raise_i && !a_busy;
    end
    tests_run++;
    if (got !== want) begin
      tests_failed++; $display("FAIL grant_order got %s want %s", got, want);
    end
    tests_run++;
    if (both_ack !== 1'b0 || done !== 1'b1) begin
      tests_failed++; $display("FAIL grant_drain got both=%b done=%b want 0/1", both_ack, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_load();
    test_simultaneous();
    test_latency4();
    test_reset_mid_access();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
